// File: rtl/split_solve_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : split_solve_pkg
//  Description : Shared types and constants for the split-constraint solver
//                sequencer: FSM states, candidate slicing, LFSR taps.
//  Revision    : 1.0 - initial release
// ============================================================================
package split_solve_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Candidate bit-slice layout inside the LFSR state
    localparam int V0_LSB = 0;
    localparam int V0_W   = 13;
    localparam int V1_LSB = 13;
    localparam int V1_W   = 13;
    localparam int V2_LSB = 26;
    localparam int V2_W   = 14;
    localparam int V3_LSB = 40;
    localparam int V3_W   = 14;
    localparam int V4_LSB = 54;
    localparam int V4_W   = 8;
    localparam int CAND_W = 62;

    // Right-shifting Galois taps for x^64+x^63+x^61+x^60+1
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Field order makes the packed value equal {var_4,var_3,var_2,var_1,var_0}
    typedef struct packed {
        logic [V4_W-1:0] v4;
        logic [V3_W-1:0] v3;
        logic [V2_W-1:0] v2;
        logic [V1_W-1:0] v1;
        logic [V0_W-1:0] v0;
    } cand_t;

    function automatic cand_t slice_cand(input logic [CAND_W-1:0] s);
        cand_t c;
        c.v0 = s[V0_LSB +: V0_W];
        c.v1 = s[V1_LSB +: V1_W];
        c.v2 = s[V2_LSB +: V2_W];
        c.v3 = s[V3_LSB +: V3_W];
        c.v4 = s[V4_LSB +: V4_W];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/split_solve_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : split_solve_seq_if
//  Description : Control, checker and solution-stream signals of the solver
//                sequencer. slave = sequencer side, master = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface split_solve_seq_if
    import split_solve_pkg::*;
#(
    parameter int CNT_W = 16
) ();
    logic                start;
    logic [7:0]          req_count;
    logic [63:0]         seed;
    logic                abort;
    logic [V0_W-1:0]     cand_var_0;
    logic [V1_W-1:0]     cand_var_1;
    logic [V2_W-1:0]     cand_var_2;
    logic [V3_W-1:0]     cand_var_3;
    logic [V4_W-1:0]     cand_var_4;
    logic                chk_x;
    logic                sol_valid;
    logic                sol_ready;
    logic [CAND_W-1:0]   sol_data;
    logic                busy;
    logic                done;
    logic                fail;
    logic [CNT_W-1:0]    attempts;
    logic [CNT_W-1:0]    total_tries;

    modport slave (
        input  start, req_count, seed, abort, chk_x, sol_ready,
        output cand_var_0, cand_var_1, cand_var_2, cand_var_3, cand_var_4,
        output sol_valid, sol_data, busy, done, fail, attempts, total_tries
    );

    modport master (
        output start, req_count, seed, abort, chk_x, sol_ready,
        input  cand_var_0, cand_var_1, cand_var_2, cand_var_3, cand_var_4,
        input  sol_valid, sol_data, busy, done, fail, attempts, total_tries
    );
endinterface
`default_nettype wire

// File: rtl/split_solve_seq_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : split_lfsr
//  Description : Galois LFSR with seed load (all-zero seed replaced by 1) and
//                single-step advance. Exposes the candidate slices of the
//                next state so the caller can register them on the step.
//  Revision    : 1.0 - initial release
// ============================================================================
module split_lfsr
    import split_solve_pkg::*;
#(
    parameter int W = 64
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load_i,
    input  wire logic [W-1:0] seed_i,
    input  wire logic         step_i,
    output cand_t             next_cand_o
);
    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;
    logic [W-1:0] step_val;

    // One Galois step: shift right, fold taps in when the bit shifted out is 1
    always_comb begin
        step_val = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end

    // Load takes precedence over step; a zero seed would lock the LFSR
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? ONE : seed_i;
        end else if (step_i) begin
            lfsr_d = step_val;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= ONE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign next_cand_o = slice_cand(step_val[CAND_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/split_solve_seq.sv
`default_nettype none
// ============================================================================
//  Module      : split_solve_seq
//  Description : Pseudo-random search sequencer. Presents LFSR candidates to an
//                external combinational checker, retries up to MAX_TRIES per
//                solution and streams accepted tuples over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module split_solve_seq
    import split_solve_pkg::*;
#(
    parameter int MAX_TRIES = 1024,
    parameter int CNT_W     = 16,
    parameter int LFSR_W    = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    split_solve_seq_if.slave bus
);
    state_e             state_q, state_d;
    cand_t              cand_q, cand_d;
    logic [CAND_W-1:0]  sol_data_q, sol_data_d;
    logic               sol_valid_q, sol_valid_d;
    logic [CNT_W-1:0]   attempts_q, attempts_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [7:0]         remaining_q, remaining_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;

    logic               lfsr_load;
    logic               lfsr_step;
    cand_t              lfsr_cand;
    logic [CNT_W:0]     attempts_inc;

    split_lfsr #(
        .W (LFSR_W)
    ) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (lfsr_load),
        .seed_i      (LFSR_W'(bus.seed)),
        .step_i      (lfsr_step),
        .next_cand_o (lfsr_cand)
    );

    // Extra bit keeps the budget compare exact when MAX_TRIES == 2**CNT_W
    assign attempts_inc = {1'b0, attempts_q} + (CNT_W+1)'(1);

    // Next-state and datapath updates; abort overrides every state
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        sol_data_d  = sol_data_q;
        sol_valid_d = sol_valid_q;
        attempts_d  = attempts_q;
        total_d     = total_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        if (bus.abort) begin
            state_d     = IDLE;
            sol_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        lfsr_load   = 1'b1;
                        remaining_d = bus.req_count;
                        total_d     = '0;
                        attempts_d  = '0;
                        if (bus.req_count == 8'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = GEN;
                        end
                    end
                end
                GEN: begin
                    lfsr_step = 1'b1;
                    cand_d    = lfsr_cand;
                    state_d   = EVAL;
                end
                EVAL: begin
                    total_d = (total_q == '1) ? total_q : total_q + CNT_W'(1);
                    if (bus.chk_x) begin
                        sol_data_d  = cand_q;
                        sol_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        attempts_d = attempts_inc[CNT_W-1:0];
                        if (attempts_inc == (CNT_W+1)'(MAX_TRIES)) begin
                            fail_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = GEN;
                        end
                    end
                end
                HOLD: begin
                    if (bus.sol_ready) begin
                        sol_valid_d = 1'b0;
                        attempts_d  = '0;
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = GEN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // All sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            sol_data_q  <= '0;
            sol_valid_q <= 1'b0;
            attempts_q  <= '0;
            total_q     <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            sol_data_q  <= sol_data_d;
            sol_valid_q <= sol_valid_d;
            attempts_q  <= attempts_d;
            total_q     <= total_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.cand_var_0  = cand_q.v0;
    assign bus.cand_var_1  = cand_q.v1;
    assign bus.cand_var_2  = cand_q.v2;
    assign bus.cand_var_3  = cand_q.v3;
    assign bus.cand_var_4  = cand_q.v4;
    assign bus.sol_valid   = sol_valid_q;
    assign bus.sol_data    = sol_data_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.fail        = fail_q;
    assign bus.attempts    = attempts_q;
    assign bus.total_tries = total_q;

endmodule
`default_nettype wire

// File: tb/tb_split_solve_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_split_solve_seq
//  Description : Self-checking bench for split_solve_seq with a queue-based
//                scoreboard on the solution stream and directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_split_solve_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    split_solve_seq_if #(.CNT_W(16)) bus ();

    split_solve_seq #(
        .MAX_TRIES (4),
        .CNT_W     (16),
        .LFSR_W    (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Checker model: 0 -> always satisfied, 1 -> never, 2 -> var_4 == 8'h03
    int chk_mode = 0;
    assign bus.chk_x = (chk_mode == 0) ? 1'b1 :
                       (chk_mode == 1) ? 1'b0 : (bus.cand_var_4 == 8'h03);

    int          checks = 0;
    int          errors = 0;
    logic [61:0] sb_q[$];
    bit          valid_seen = 1'b0;

    function automatic logic [63:0] lstep(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [63:0] s, input logic [7:0] r);
        bus.seed      = s;
        bus.req_count = r;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Ticks until done or fail is high, at most maxc cycles
    task automatic wait_evt(input int maxc, output int n);
        n = 0;
        while (n < maxc && !(bus.done || bus.fail)) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (n < maxc && !bus.sol_valid) begin
            tick();
            n++;
        end
    endtask

    // Monitor: every handshake pops and compares one expected tuple
    always @(negedge clk) begin
        if (rst_n && bus.sol_valid) valid_seen = 1'b1;
        if (rst_n && bus.sol_valid && bus.sol_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", bus.sol_data);
            end else begin
                logic [61:0] exp;
                exp = sb_q.pop_front();
                if (bus.sol_data !== exp) begin
                    errors++;
                    $display("FAIL sb_data actual=%0h required=%0h", bus.sol_data, exp);
                end
            end
        end
    end

    initial begin
        logic [63:0] s;
        int          n;
        bit          stable;

        bus.start = 1'b0; bus.abort = 1'b0; bus.sol_ready = 1'b0;
        bus.seed = 64'h0; bus.req_count = 8'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.sol_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_flags", {bus.done, bus.fail}, 0);
        check("rst_cnts", {bus.attempts, bus.total_tries}, 0);
        check("rst_data", {bus.sol_data, bus.cand_var_0}, 0);
        rst_n = 1'b1;
        tick();

        // Always-satisfied checker, 3 solutions from seed 1
        chk_mode = 0; bus.sol_ready = 1'b1;
        s = 64'h1;
        for (int i = 0; i < 3; i++) begin s = lstep(s); sb_q.push_back(s[61:0]); end
        start_run(64'h1, 8'd3);
        check("t1_busy", bus.busy, 1);
        tick(); tick();
        check("t1_latency", bus.sol_valid, 1);
        check("t1_first", bus.sol_data, 62'h1800_0000_0000_0000);
        wait_evt(30, n);
        check("t1_done_cycle", n, 7);
        check("t1_done_nofail", {bus.done, bus.fail}, 2'b10);
        check("t1_total", bus.total_tries, 3);
        tick();
        check("t1_done_pulse", {bus.done, bus.busy}, 0);

        // Never-satisfied checker: budget of 4 exhausted
        chk_mode = 1; valid_seen = 1'b0;
        start_run(64'h5, 8'd2);
        wait_evt(30, n);
        check("t2_fail_cycle", n, 8);
        check("t2_fail_nodone", {bus.done, bus.fail}, 2'b01);
        check("t2_attempts", bus.attempts, 4);
        check("t2_total", bus.total_tries, 4);
        tick();
        check("t2_fail_pulse", {bus.fail, bus.busy}, 0);
        check("t2_no_valid", valid_seen, 0);

        // Selective checker, downstream stalled 10 cycles
        chk_mode = 2; bus.sol_ready = 1'b0;
        s = 64'h0600_0000_0000_0000;
        s = lstep(lstep(lstep(s)));
        check("t3_model", s[61:0], 62'h00C0_0000_0000_0000);
        sb_q.push_back(s[61:0]);
        start_run(64'h0600_0000_0000_0000, 8'd1);
        wait_valid(30, n);
        check("t3_valid_cycle", n, 6);
        check("t3_attempts", bus.attempts, 2);
        check("t3_total", bus.total_tries, 3);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(bus.sol_valid && bus.sol_data == 62'h00C0_0000_0000_0000 &&
                  bus.cand_var_4 == 8'h03 && bus.cand_var_3 == 14'h0)) stable = 1'b0;
        end
        check("t3_stable", stable, 1);
        check("t3_var4", bus.sol_data[61:54], 8'h03);
        bus.sol_ready = 1'b1;
        wait_evt(10, n);
        check("t3_done_cycle", n, 1);

        // Zero requested solutions
        start_run(64'h7, 8'd0);
        check("t4_zero_done", {bus.done, bus.busy}, 2'b10);
        tick();
        check("t4_zero_pulse", bus.done, 0);

        // Zero seed behaves like seed 1
        chk_mode = 0;
        s = lstep(64'h1);
        sb_q.push_back(s[61:0]);
        start_run(64'h0, 8'd1);
        wait_evt(20, n);
        check("t4_seed0_done", n, 3);

        // Abort in HOLD
        bus.sol_ready = 1'b0;
        start_run(64'h1, 8'd2);
        tick(); tick();
        check("t5_hold_valid", bus.sol_valid, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_hold_abort", {bus.sol_valid, bus.busy, bus.done, bus.fail}, 0);
        // Abort in EVAL
        start_run(64'h9, 8'd1);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_eval_abort", {bus.sol_valid, bus.busy, bus.done, bus.fail}, 0);
        tick();
        check("t5_no_pulse", {bus.done, bus.fail}, 0);
        bus.sol_ready = 1'b1;
        s = lstep(64'h1);
        sb_q.push_back(s[61:0]);
        start_run(64'h1, 8'd1);
        wait_evt(20, n);
        check("t5_restart", n, 3);

        // Asynchronous reset mid-EVAL, then reproduce the sequence
        start_run(64'h1, 8'd2);
        tick();
        check("t6_cand_pre", bus.cand_var_4, 8'h60);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_outs", {bus.sol_valid, bus.busy, bus.done, bus.fail, bus.cand_var_4}, 0);
        check("t6_async_cnts", {bus.attempts, bus.total_tries}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        s = 64'h1;
        for (int i = 0; i < 2; i++) begin s = lstep(s); sb_q.push_back(s[61:0]); end
        start_run(64'h1, 8'd2);
        wait_evt(30, n);
        check("t6_repeat_done", n, 6);
        tick();
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
